// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, word width, FSM states and Rcon.
// AES_KEY_SCHED_REG_SUB_EN adds the CALC state used by the registered-SubWord build.
package aes_pkg;

    localparam int NR         = 10;
    localparam int AES_WORD_W = 32;

`ifdef AES_KEY_SCHED_REG_SUB_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_CALC,
        S_DONE
    } ks_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_DONE
    } ks_state_t;
`endif

    // Round constant for round 1..10; only the MSB byte of the word is non-zero.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box for one byte, as a constant lookup table.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 on-the-fly key expansion with a valid/ready round-key output.
// AES_KEY_SCHED_REG_SUB_EN registers SubWord and adds a CALC bubble per round.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] rnd_key,
    output logic [3:0]   rnd_no,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    ks_state_t             state;
    logic [AES_WORD_W-1:0] w0, w1, w2, w3;
    logic [AES_WORD_W-1:0] rot_w, sub_comb, sub_w, t_w;
    logic [AES_WORD_W-1:0] n0, n1, n2, n3;
    logic [3:0]            rnd_next;

    assign {w0, w1, w2, w3} = rnd_key;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot_w[8*b +: 8]),
            .y (sub_comb[8*b +: 8])
        );
    end

`ifdef AES_KEY_SCHED_REG_SUB_EN
    // rnd_key is stable through PRESENT, so the value captured on leaving it matches CALC's key.
    logic [AES_WORD_W-1:0] sub_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_reg <= '0;
        end else begin
            sub_reg <= sub_comb;
        end
    end

    assign sub_w = sub_reg;
`else
    assign sub_w = sub_comb;
`endif

    assign rnd_next = rnd_no + 4'd1;
    assign t_w      = sub_w ^ {rcon(rnd_next), 24'h000000};
    assign n0       = w0 ^ t_w;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rnd_key   <= '0;
            rnd_no    <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rnd_key   <= key_in;
                        rnd_no    <= 4'd0;
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (key_ready) begin
                        if (rnd_no == LAST_RND) begin
                            key_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
`ifdef AES_KEY_SCHED_REG_SUB_EN
                            key_valid <= 1'b0;
                            state     <= S_CALC;
`else
                            rnd_key <= {n0, n1, n2, n3};
                            rnd_no  <= rnd_next;
`endif
                        end
                    end
                end
`ifdef AES_KEY_SCHED_REG_SUB_EN
                S_CALC: begin
                    rnd_key   <= {n0, n1, n2, n3};
                    rnd_no    <= rnd_next;
                    key_valid <= 1'b1;
                    state     <= S_PRESENT;
                end
`endif
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    key_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: FIPS-197 and zero-key vectors plus multi-cycle corner cases.
// Honours AES_KEY_SCHED_REG_SUB_EN for the two-cycle-per-round timing.
module tb_aes_key_sched;

`ifdef AES_KEY_SCHED_REG_SUB_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [127:0] key;
        logic [127:0] r1;
        logic [127:0] r10;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic [127:0] rnd_key;
    logic [3:0]   rnd_no;
    logic         key_valid;
    logic         busy;
    logic         done;

    int           checks;
    int           errors;
    logic [127:0] seen_key [0:10];

    aes_key_sched #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .rnd_key   (rnd_key),
        .rnd_no    (rnd_no),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents start with the key for one cycle; returns #1 after the capturing edge.
    task automatic applyStimulus(input logic [127:0] key);
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic clearSeen();
        for (int i = 0; i <= 10; i++) seen_key[i] = '0;
    endtask

    // Samples each negedge, capturing presented keys, until done or the cycle budget expires.
    task automatic runToDone(output int done_cycle, output int valid_cycles);
        done_cycle   = -1;
        valid_cycles = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                valid_cycles++;
                seen_key[rnd_no] = rnd_key;
            end
            if (done === 1'b1) begin
                done_cycle = c;
                break;
            end
        end
    endtask

    task automatic waitForRound(input logic [3:0] r, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (key_valid === 1'b1 && rnd_no === r) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        vec_t         vecs [2];
        int           done_cycle;
        int           valid_cycles;
        bit           ok;
        bit           saw_done;
        logic [127:0] held_key;

        checks    = 0;
        errors    = 0;
        start     = 1'b0;
        key_in    = '0;
        key_ready = 1'b0;
        rst       = 1'b1;

        vecs[0] = '{key: FIPS_KEY, r1: FIPS_R1, r10: FIPS_R10};
        vecs[1] = '{key: 128'h0,   r1: ZERO_R1, r10: ZERO_R10};

        #12;
        checkOutput("reset rnd_key", rnd_key, 128'h0);
        checkOutput("reset rnd_no", 128'(rnd_no), 128'h0);
        checkOutput("reset key_valid", 128'(key_valid), 128'h0);
        checkOutput("reset busy", 128'(busy), 128'h0);
        checkOutput("reset done", 128'(done), 128'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] table vectors, key_ready held high");
        key_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            clearSeen();
            applyStimulus(vecs[v].key);
            runToDone(done_cycle, valid_cycles);
            checkOutput($sformatf("vec%0d round0", v), seen_key[0], vecs[v].key);
            checkOutput($sformatf("vec%0d round1", v), seen_key[1], vecs[v].r1);
            checkOutput($sformatf("vec%0d round10", v), seen_key[10], vecs[v].r10);
            checkOutput($sformatf("vec%0d done cycle", v), 128'(done_cycle), 128'(2 + 10 * STEP));
            checkOutput($sformatf("vec%0d valid cycles", v), 128'(valid_cycles), 128'd11);
            checkOutput($sformatf("vec%0d rnd_key held", v), rnd_key, vecs[v].r10);
            @(negedge clk);
            checkOutput($sformatf("vec%0d busy after done", v), 128'(busy), 128'h0);
            checkOutput($sformatf("vec%0d done one cycle", v), 128'(done), 128'h0);
        end

        $display("[TB] reset at round 4");
        applyStimulus(FIPS_KEY);
        waitForRound(4'd4, ok);
        checkOutput("reach round 4", 128'(ok), 128'h1);
        rst = 1'b1;
        #1;
        checkOutput("midrun rnd_key", rnd_key, 128'h0);
        checkOutput("midrun rnd_no", 128'(rnd_no), 128'h0);
        checkOutput("midrun key_valid", 128'(key_valid), 128'h0);
        checkOutput("midrun busy", 128'(busy), 128'h0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checkOutput("no done after reset", 128'(saw_done), 128'h0);
        clearSeen();
        applyStimulus(128'h0);
        runToDone(done_cycle, valid_cycles);
        checkOutput("restart round1", seen_key[1], ZERO_R1);
        checkOutput("restart round10", seen_key[10], ZERO_R10);
        checkOutput("restart done cycle", 128'(done_cycle), 128'(2 + 10 * STEP));

        $display("[TB] backpressure at round 3");
        applyStimulus(FIPS_KEY);
        waitForRound(4'd3, ok);
        checkOutput("reach round 3", 128'(ok), 128'h1);
        key_ready = 1'b0;
        held_key  = rnd_key;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall rnd_no", 128'(rnd_no), 128'd3);
            checkOutput("stall key_valid", 128'(key_valid), 128'h1);
            checkOutput("stall rnd_key", rnd_key, held_key);
        end
        key_ready = 1'b1;
        repeat (STEP) @(negedge clk);
        checkOutput("resume rnd_no", 128'(rnd_no), 128'd4);
        checkOutput("resume key_valid", 128'(key_valid), 128'h1);
        clearSeen();
        runToDone(done_cycle, valid_cycles);
        checkOutput("backpressure round10", seen_key[10], FIPS_R10);
        checkOutput("backpressure done seen", 128'(done_cycle > 0), 128'h1);

        $display("[TB] start pulse while busy");
        applyStimulus(FIPS_KEY);
        waitForRound(4'd6, ok);
        checkOutput("reach round 6", 128'(ok), 128'h1);
        key_in = {4{32'hdeadbeef}};
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        clearSeen();
        runToDone(done_cycle, valid_cycles);
        checkOutput("busy start round10", seen_key[10], FIPS_R10);
        checkOutput("busy start done seen", 128'(done_cycle > 0), 128'h1);
        @(negedge clk);
        checkOutput("busy start idle", 128'(busy), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Sequential AES-128 key-expansion controller. It captures a 128-bit cipher key on `start` and steps the round counter from 0 to 10. For each round it computes that round's key on the fly and hands it to the cipher datapath over a valid/ready handshake. It owns round sequencing and the Rcon lookup, so the cipher core only consumes `rnd_key` together with `rnd_no`.

## Interface
- `NR`, default 10, number of rounds; fixed at 10 for AES-128, other values are illegal.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin expansion of `key_in`; honoured only in IDLE.
- `key_in` in 128: cipher key, sampled on the cycle `start` is accepted.
- `key_ready` in 1: consumer accepts the current `rnd_key`.
- `rnd_key` out 128: current round key, words w0..w3 in bits [127:96]..[31:0].
- `rnd_no` out 4: round index of `rnd_key`, 0..10.
- `key_valid` out 1: `rnd_key` and `rnd_no` are valid.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after round 10 is accepted.

## Operation
- States: IDLE, PRESENT, CALC, DONE.
- IDLE:
  - On `start`, register `key_in` into `rnd_key` and set `rnd_no`=0.
  - Next state is PRESENT.
- PRESENT:
  - `key_valid`=1.
  - Hold `rnd_key` and `rnd_no` stable until `key_valid && key_ready`.
  - On that handshake with `rnd_no`<10, compute the next key and increment `rnd_no`. Next state is PRESENT without the macro, or CALC with it.
  - On that handshake with `rnd_no`=10, next state is DONE.
- Next-key arithmetic (i = new `rnd_no`, all XORs 32-bit):
  - t = SubWord(RotWord(w3)) ^ Rcon(i).
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Rcon(i) values for i=1..10: 01,02,04,08,10,20,40,80,1b,36, placed in the MSB byte.
- CALC:
  - Exists only with the macro; `key_valid`=0.
  - Applies the registered SubWord result, then goes to PRESENT.
- DONE:
  - `done`=1 for one cycle, `key_valid`=0.
  - Next state is IDLE. `rnd_key` retains the round-10 key.
- `start` while `busy` is ignored and does not restart.
- `key_ready` while `key_valid`=0 is ignored.
- A `rst` assertion in any state forces IDLE immediately. Any partial expansion is discarded and no `done` is issued.

## Timing
- Reset values: `rnd_key`=0, `rnd_no`=0, `key_valid`=0, `busy`=0, `done`=0, state IDLE.
- Latency from `start` to round-0 `key_valid`: 1 cycle.
- Throughput without the macro: one round key per cycle while `key_ready` is held high. The round-0 key is visible at T+1, round 10 at T+11, `done` at T+12, and `busy` falls at T+13.
- With the macro: two cycles per round after round 0, i.e. one bubble per round. Round 10 is visible at T+21.
- `rnd_key` and `rnd_no` change only on a handshake or on the `start` capture.

## Configuration
- `AES_KEY_SCHED_REG_SUB_EN` defined:
  - The SubWord(RotWord(w3)) output is registered.
  - The CALC state is present and inserts one bubble cycle per round to shorten the S-box→XOR path.
- Undefined:
  - SubWord is combinational in the same cycle as the XOR chain.
  - CALC is unreachable and excluded from the state encoding.

## Structure
- Shared package `aes_pkg` holds:
  - `NR`=10 and `AES_WORD_W`=32.
  - The state enum typedef `ks_state_t`.
  - The Rcon constant function indexed by round number, returning the same values as the codebase's round-constant block.
- Sub-module `aes_sbox`: a byte S-box, instantiated four times for SubWord. The controller contains only the FSM, counter, key register and XOR chain.

## Test plan
- Reset mid-run:
  - Start, then assert `rst` while `rnd_no`=4.
  - Outputs return to reset values immediately; no `done` follows.
  - A new `start` after reset runs cleanly from round 0.
- FIPS-197 key with `key_ready` held high:
  - `key_in`=2b7e151628aed2a6abf7158809cf4f3c.
  - Round 0 = the key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` asserts at T+12.
- Backpressure:
  - Hold `key_ready`=0 for 5 cycles at `rnd_no`=3.
  - `rnd_key` and `rnd_no`=3 stay stable and `key_valid` stays 1.
  - Round 4 is presented on the cycle after `key_ready` rises.
- `start` during busy:
  - Pulse `start` with a different `key_in` while at `rnd_no`=6.
  - The sequence is unaffected and round 10 still equals d014f9a8....
- All-zero key:
  - `key_in`=0.
  - Round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Macro build:
  - Run the FIPS-197 case with `AES_KEY_SCHED_REG_SUB_EN` defined.
  - Same keys as the non-macro run, `key_valid` low one cycle between rounds, round 10 at T+21.
